aec_tx: RTL and testbench

Stimulus-side transmitter for the arithmetic expression calculator (AEC) ASCII interface. It accepts up to 16 expression tokens over a valid/ready load port and streams them as an ASCII character sequence, one character per cycle, terminated by '='. It then waits for the calculator's `valid`/`result` response and returns the captured result, with a watchdog for a response that never arrives. It sits in front of an AEC instance in system and test harnesses.

---
 rtl/aec_pkg.sv | 49 ++++
 rtl/aec_tok_buf.sv | 61 ++++++
 rtl/aec_tx.sv | 161 ++++++++++++++++
 tb/tb_aec_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// Shared definitions for the AEC ASCII transmitter: token codes, ASCII codes,
// the controller state encoding and the token-to-character mapping.
package aec_pkg;

  localparam logic [4:0] TOK_LPAR = 5'd16;
  localparam logic [4:0] TOK_RPAR = 5'd17;
  localparam logic [4:0] TOK_MUL  = 5'd18;
  localparam logic [4:0] TOK_ADD  = 5'd19;
  localparam logic [4:0] TOK_SUB  = 5'd20;

  localparam logic [7:0] ASC_NUL  = 8'd0;
  localparam logic [7:0] ASC_0    = 8'd48;
  localparam logic [7:0] ASC_A    = 8'd97;
  localparam logic [7:0] ASC_LPAR = 8'd40;
  localparam logic [7:0] ASC_RPAR = 8'd41;
  localparam logic [7:0] ASC_MUL  = 8'd42;
  localparam logic [7:0] ASC_ADD  = 8'd43;
  localparam logic [7:0] ASC_SUB  = 8'd45;
  localparam logic [7:0] ASC_EQ   = 8'd61;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TERM,
    ST_WAIT,
    ST_DONE
  } aec_state_e;

  function automatic logic [7:0] tok_to_ascii(input logic [4:0] tok);
    logic [7:0] a;
    a = ASC_NUL;
    if (tok < 5'd10) begin
      a = ASC_0 + {3'b000, tok};
    end else if (tok < TOK_LPAR) begin
      a = ASC_A + {3'b000, tok - 5'd10};
    end else begin
      case (tok)
        TOK_LPAR: a = ASC_LPAR;
        TOK_RPAR: a = ASC_RPAR;
        TOK_MUL:  a = ASC_MUL;
        TOK_ADD:  a = ASC_ADD;
        TOK_SUB:  a = ASC_SUB;
        default:  a = ASC_NUL;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/aec_tok_buf.sv
// Token buffer for aec_tx: DEPTH x 5 storage with wrapping pointers, an
// occupancy count, registered read and a synchronous clear.
module aec_tok_buf #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [4:0]    wr_data,
  input  logic          rd_en,
  output logic [4:0]    rd_data,
  output logic [CW-1:0] count
);

  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_addr;
  logic [4:0]    rd_data_q;

  // Read one entry ahead so the entry at the new pointer is on rd_data next cycle.
  always_comb begin
    rd_addr = rd_ptr_q;
    if (clr) begin
      rd_addr = '0;
    end else if (rd_en) begin
      rd_addr = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        count_q  <= count_q + CW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/aec_tx.sv
// AEC stimulus transmitter: buffers tokens, streams them as ASCII ending in '=',
// then waits (with watchdog) for the calculator result. AEC_TX_CHECK_EN adds the
// expected-result comparison driving mismatch.
module aec_tx
  import aec_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TMO_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [4:0] tok_data,
  output logic       tok_ready,
  input  logic       start,
  input  logic [6:0] exp_in,
  output logic       ready,
  output logic [7:0] ascii_out,
  input  logic       res_valid,
  input  logic [6:0] res_in,
  output logic       busy,
  output logic       done,
  output logic [6:0] result,
  output logic       timeout,
  output logic       mismatch
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TMO_CYC + 1);

  aec_state_e    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [6:0]    result_q, result_d;
  logic          timeout_q, timeout_d;
  logic          mismatch_q, mismatch_d;

  logic [CW-1:0] count;
  logic [4:0]    rd_data;
  logic          start_acc, wr_en, rd_en, clr, wd_exp;

  assign start_acc = (state_q == ST_IDLE) && start && (count != '0);
  assign tok_ready = (state_q == ST_IDLE) && (count < CW'(DEPTH)) && !start_acc;
  // Out-of-range codes are acknowledged but never stored.
  assign wr_en     = tok_valid && tok_ready && (tok_data <= TOK_SUB);
  assign rd_en     = (state_q == ST_SEND);
  assign wd_exp    = (wd_q == WW'(TMO_CYC - 1));
  assign clr       = (state_q == ST_WAIT) && (res_valid || wd_exp);

  aec_tok_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (tok_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count)
  );

`ifdef AEC_TX_CHECK_EN
  logic [6:0] exp_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= '0;
    end else if (start_acc) begin
      exp_q <= exp_in;
    end
  end
`else
  logic unused_exp;
  assign unused_exp = ^exp_in;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    mismatch_d = mismatch_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        idx_d = idx_q + CW'(1);
        if (idx_q == count - CW'(1)) begin
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        state_d = ST_WAIT;
        wd_d    = '0;
      end
      ST_WAIT: begin
        wd_d = wd_q + WW'(1);
        // A response in the expiry cycle still counts as a response.
        if (res_valid) begin
          state_d   = ST_DONE;
          result_d  = res_in;
          timeout_d = 1'b0;
`ifdef AEC_TX_CHECK_EN
          mismatch_d = (res_in != exp_q);
`else
          mismatch_d = 1'b0;
`endif
        end else if (wd_exp) begin
          state_d   = ST_DONE;
          result_d  = '0;
          timeout_d = 1'b1;
`ifdef AEC_TX_CHECK_EN
          mismatch_d = 1'b1;
`else
          mismatch_d = 1'b0;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wd_q       <= '0;
      result_q   <= '0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    ascii_out = ASC_NUL;
    if (state_q == ST_SEND) begin
      ascii_out = tok_to_ascii(rd_data);
    end else if (state_q == ST_TERM) begin
      ascii_out = ASC_EQ;
    end
  end

  assign ready    = (state_q == ST_SEND) && (idx_q == '0);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign timeout  = timeout_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_aec_tx.sv
// Randomised scoreboard bench for aec_tx: expected characters and completions
// are queued at stimulus time and popped by a negedge monitor.
module tb_aec_tx;

  localparam int DEPTH = 16;
  localparam int TMO   = 255;
`ifdef AEC_TX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tok_valid = 1'b0;
  logic [4:0] tok_data = '0;
  logic       start = 1'b0;
  logic [6:0] exp_in = '0;
  logic       res_valid = 1'b0;
  logic [6:0] res_in = '0;
  logic       tok_ready, ready, busy, done, timeout, mismatch;
  logic [7:0] ascii_out;
  logic [6:0] result;

  aec_tx #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok_data  (tok_data),
    .tok_ready (tok_ready),
    .start     (start),
    .exp_in    (exp_in),
    .ready     (ready),
    .ascii_out (ascii_out),
    .res_valid (res_valid),
    .res_in    (res_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .timeout   (timeout),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; int rdy; int cyc; } chr_t;
  typedef struct { int res; int tmo; int mis; int cyc; } dn_t;
  chr_t exp_chr[$];
  dn_t  exp_dn[$];
  int   mq[$];
  int   mexp = 0;
  int   checks = 0;
  int   passes = 0;
  string hexs = "0123456789abcdef";
  string ops  = "()*+-";

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic int asc_of(int code);
    if (code < 16) return int'(hexs[code]);
    return int'(ops[code - 16]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(int code);
    int er;
    tok_valid = 1'b1;
    tok_data  = 5'(code);
    #1;
    er = (mq.size() < DEPTH) ? 1 : 0;
    chk("tok_ready", int'(tok_ready), er);
    tick();
    tok_valid = 1'b0;
    if (er == 1 && code <= 20) mq.push_back(code);
  endtask

  task automatic do_start(int ev, output int n, output int c0);
    chr_t c;
    start  = 1'b1;
    exp_in = 7'(ev);
    c0 = cyc;
    n  = mq.size();
    if (n > 0) begin
      for (int k = 0; k < n; k++) begin
        c.ch = asc_of(mq[k]); c.rdy = (k == 0) ? 1 : 0; c.cyc = c0 + 1 + k;
        exp_chr.push_back(c);
      end
      c.ch = 61; c.rdy = 0; c.cyc = c0 + 1 + n;
      exp_chr.push_back(c);
      mexp = ev;
    end
    mq.delete();
    tick();
    start = 1'b0;
  endtask

  // Drive res_valid d cycles after WAIT entry; d >= TMO means no response in time.
  task automatic respond(int n, int c0, int d, int v);
    dn_t e;
    int w, dc;
    w = c0 + n + 2;
    if (d < TMO) begin
      e.res = v; e.tmo = 0; e.mis = CHK ? ((v != mexp) ? 1 : 0) : 0; e.cyc = w + d + 1;
    end else begin
      e.res = 0; e.tmo = 1; e.mis = CHK ? 1 : 0; e.cyc = w + TMO;
    end
    dc = e.cyc;
    exp_dn.push_back(e);
    $display("txn: tokens=%0d resp_delay=%0d resp=%0d exp=%0d -> result=%0d timeout=%0d mismatch=%0d",
             n, d, v, mexp, e.res, e.tmo, e.mis);
    while (cyc < w + d) tick();
    res_valid = 1'b1;
    res_in    = 7'(v);
    tick();
    res_valid = 1'b0;
    while (cyc <= dc) tick();
  endtask

  chr_t mc;
  dn_t  md;
  always @(negedge clk) begin
    if (ascii_out != 8'd0 || ready) begin
      if (exp_chr.size() == 0) chk("unexpected_char", int'({ready, ascii_out}), 0);
      else begin
        mc = exp_chr.pop_front();
        chk("char", int'(ascii_out), mc.ch);
        chk("ready", int'(ready), mc.rdy);
        chk("char_cycle", cyc, mc.cyc);
      end
    end
    if (done) begin
      if (exp_dn.size() == 0) chk("unexpected_done", int'(done), 0);
      else begin
        md = exp_dn.pop_front();
        chk("result", int'(result), md.res);
        chk("timeout", int'(timeout), md.tmo);
        chk("mismatch", int'(mismatch), md.mis);
        chk("done_cycle", cyc, md.cyc);
      end
    end
  end

  initial begin
    int n, c0, rc, w, ev, v, d, ntry;
    int t1[5] = '{3, 19, 4, 18, 2};
    int t2[7] = '{16, 10, 20, 1, 17, 18, 15};

    tick(); tick();
    chk("rst_tok_ready", int'(tok_ready), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_ascii", int'(ascii_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    rst = 1'b1;
    tick();

    // Worked example, plus a res_valid pulse during SEND that must be ignored.
    foreach (t1[i]) offer(t1[i]);
    do_start(11, n, c0);
    tick();
    res_valid = 1'b1; res_in = 7'd99;
    tick();
    res_valid = 1'b0;
    respond(n, c0, 3, 11);

    foreach (t2[i]) offer(t2[i]);
    do_start(5, n, c0);
    respond(n, c0, 0, 5);

    // Full buffer with a dropped code in the middle, a rejected 17th token,
    // and a response coinciding with watchdog expiry.
    for (int i = 0; i < 16; i++) begin
      offer($urandom_range(0, 20));
      if (i == 7) offer(25);
    end
    offer(7);
    do_start(42, n, c0);
    chk("full_count", n, 16);
    respond(n, c0, TMO - 1, 42);

    // Reset mid-SEND.
    offer(1); offer(19); offer(2); offer(18); offer(3);
    do_start(11, n, c0);
    tick();
    rst = 1'b0;
    rc  = cyc;
    tick();
    rst = 1'b1;
    while (exp_chr.size() > 0 && exp_chr[$].cyc > rc) void'(exp_chr.pop_back());
    #1;
    chk("rstmid_ascii", int'(ascii_out), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_result", int'(result), 0);
    chk("rstmid_tok_ready", int'(tok_ready), 1);
    chk("rstmid_done", int'(done), 0);
    $display("txn: reset during SEND at cycle %0d", rc);

    // Empty buffer after the reset: start must be ignored.
    do_start(0, n, c0);
    for (int i = 0; i < 3; i++) begin
      chk("empty_busy", int'(busy), 0);
      tick();
    end
    $display("txn: start with empty buffer");

    // Timeout, with a start pulse during WAIT that must be ignored.
    offer(1); offer(19); offer(2);
    do_start(33, n, c0);
    w = c0 + n + 2;
    while (cyc < w + 3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    respond(n, c0, TMO + 2, 0);

    offer(1); offer(18); offer(1);
    do_start(11, n, c0);
    respond(n, c0, 2, 12);

    for (int t = 0; t < 25; t++) begin
      ntry = $urandom_range(0, 18);
      for (int i = 0; i < ntry; i++) offer($urandom_range(0, 31));
      ev = $urandom_range(0, 127);
      v  = ($urandom_range(0, 1) == 1) ? ev : $urandom_range(0, 127);
      do_start(ev, n, c0);
      if (n == 0) begin
        chk("rand_empty_busy", int'(busy), 0);
        $display("txn: random start with empty buffer");
      end else begin
        d = ($urandom_range(0, 3) == 0) ? (TMO - 2 + $urandom_range(0, 3)) : $urandom_range(0, 9);
        respond(n, c0, d, v);
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (4) tick();
    chk("chars_drained", exp_chr.size(), 0);
    chk("dones_drained", exp_dn.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
